// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALUOp/funct into the ALU control code, forwards operands, and holds one op under valid/ready.
// Define ALU_ISSUE_FWD_EN to enable the EX/MEM and MEM/WB forwarding muxes.
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             alu_src,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    input  logic             exm_wr,
    input  logic             mwb_wr,
    input  logic [4:0]       exm_rd,
    input  logic [4:0]       mwb_rd,
    input  logic [XLEN-1:0]  exm_data,
    input  logic [XLEN-1:0]  mwb_data,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_control,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0]       CTRL_AND = 4'b0000;
    localparam logic [3:0]       CTRL_OR  = 4'b0001;
    localparam logic [3:0]       CTRL_ADD = 4'b0010;
    localparam logic [3:0]       CTRL_SUB = 4'b0110;
    localparam logic [3:0]       CTRL_ILL = 4'b1111;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rs1_fwd, rs2_fwd;
    logic             accept, stall;

    // Ready never looks at in_valid, so upstream can't form a combinational loop through us.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign stall    = valid_q && !out_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ctrl_d    = CTRL_ADD;
        illegal_d = 1'b0;
        case (alu_op)
            2'b00: ctrl_d = CTRL_ADD;
            2'b01: ctrl_d = CTRL_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  ctrl_d = funct7_5 ? CTRL_SUB : CTRL_ADD;
                    3'b111:  ctrl_d = CTRL_AND;
                    3'b110:  ctrl_d = CTRL_OR;
                    default: begin
                        ctrl_d    = CTRL_ILL;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            default: begin
                ctrl_d    = CTRL_ILL;
                illegal_d = 1'b1;
            end
        endcase
    end

`ifdef ALU_ISSUE_FWD_EN
    // EX/MEM is the younger producer so it wins; x0 is hard-wired zero and never forwarded.
    function automatic logic [XLEN-1:0] fwd(input logic [4:0] addr, input logic [XLEN-1:0] reg_data,
                                            input logic e_wr, input logic [4:0] e_rd, input logic [XLEN-1:0] e_data,
                                            input logic m_wr, input logic [4:0] m_rd, input logic [XLEN-1:0] m_data);
        if (e_wr && e_rd != 5'd0 && e_rd == addr)      fwd = e_data;
        else if (m_wr && m_rd != 5'd0 && m_rd == addr) fwd = m_data;
        else                                           fwd = reg_data;
    endfunction

    assign rs1_fwd = fwd(rs1_addr, rs1_data, exm_wr, exm_rd, exm_data, mwb_wr, mwb_rd, mwb_data);
    assign rs2_fwd = fwd(rs2_addr, rs2_data, exm_wr, exm_rd, exm_data, mwb_wr, mwb_rd, mwb_data);
`else
    logic unused_fwd;
    assign unused_fwd = ^{exm_wr, mwb_wr, exm_rd, mwb_rd, exm_data, mwb_data, rs1_addr, rs2_addr};
    assign rs1_fwd    = rs1_data;
    assign rs2_fwd    = rs2_data;
`endif

    assign a_d = rs1_fwd;
    assign b_d = alu_src ? imm : rs2_fwd;

    always_comb begin
        valid_d = valid_q;
        if (flush)          valid_d = 1'b0;
        else if (accept)    valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
    end

    assign cnt_d = (stall && cnt_q != '1) ? cnt_q + CNT_ONE : cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= 4'b0000;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                a_q       <= a_d;
                b_q       <= b_d;
                ctrl_q    <= ctrl_d;
                illegal_q <= illegal_d;
            end
        end
    end

    assign out_valid   = valid_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_control = ctrl_q;
    assign illegal     = illegal_q;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: scoreboard of issued ops plus directed checks of decode, forwarding, stalls, flush and reset.
`timescale 1ns/1ps
module tb_alu_issue_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [1:0]       alu_op;
    logic [2:0]       funct3;
    logic             funct7_5, alu_src;
    logic [4:0]       rs1_addr, rs2_addr;
    logic [XLEN-1:0]  rs1_data, rs2_data, imm;
    logic             exm_wr, mwb_wr;
    logic [4:0]       exm_rd, mwb_rd;
    logic [XLEN-1:0]  exm_data, mwb_data;
    logic             flush, out_ready, out_valid;
    logic [XLEN-1:0]  alu_a, alu_b;
    logic [3:0]       alu_control;
    logic             illegal;
    logic [CNT_W-1:0] stall_cnt;

    typedef struct {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      ctrl;
        logic            ill;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [3:0] exp_stall = '0;

`ifdef ALU_ISSUE_FWD_EN
    localparam logic [XLEN-1:0] EXP_A_FWD = 32'hAA;
    localparam logic [XLEN-1:0] EXP_B_FWD = 32'hBB;
`else
    localparam logic [XLEN-1:0] EXP_A_FWD = 32'h11;
    localparam logic [XLEN-1:0] EXP_B_FWD = 32'h02;
`endif

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .alu_src(alu_src),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .exm_wr(exm_wr), .mwb_wr(mwb_wr), .exm_rd(exm_rd), .mwb_rd(mwb_rd),
        .exm_data(exm_data), .mwb_data(mwb_data), .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .illegal(illegal), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        e.ctrl = 4'b0010;
        e.ill  = 1'b0;
        case (alu_op)
            2'b00: e.ctrl = 4'b0010;
            2'b01: e.ctrl = 4'b0110;
            2'b10: begin
                if (funct3 == 3'b000)      e.ctrl = funct7_5 ? 4'b0110 : 4'b0010;
                else if (funct3 == 3'b111) e.ctrl = 4'b0000;
                else if (funct3 == 3'b110) e.ctrl = 4'b0001;
                else begin e.ctrl = 4'b1111; e.ill = 1'b1; end
            end
            default: begin e.ctrl = 4'b1111; e.ill = 1'b1; end
        endcase
        e.a = rs1_data;
        e.b = alu_src ? imm : rs2_data;
`ifdef ALU_ISSUE_FWD_EN
        if (exm_wr && exm_rd != 0 && exm_rd == rs1_addr)      e.a = exm_data;
        else if (mwb_wr && mwb_rd != 0 && mwb_rd == rs1_addr) e.a = mwb_data;
        if (!alu_src) begin
            if (exm_wr && exm_rd != 0 && exm_rd == rs2_addr)      e.b = exm_data;
            else if (mwb_wr && mwb_rd != 0 && mwb_rd == rs2_addr) e.b = mwb_data;
        end
`endif
        return e;
    endfunction

    // Called just after a falling edge with inputs set; checks, updates the scoreboard, then steps one cycle.
    task automatic tick();
        bit mv;
        #1;
        mv = (sb.size() != 0);
        check("out_valid", out_valid, mv);
        check("in_ready", in_ready, !mv || out_ready);
        check("stall_cnt", stall_cnt, exp_stall);
        if (mv) begin
            check("alu_a", alu_a, sb[0].a);
            check("alu_b", alu_b, sb[0].b);
            check("alu_control", alu_control, sb[0].ctrl);
            check("illegal", illegal, sb[0].ill);
            if (out_ready || flush) void'(sb.pop_front());
            if (!out_ready && exp_stall != 4'hF) exp_stall++;
        end
        if (in_valid && (!mv || out_ready) && !flush) sb.push_back(model());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [2:0] f3, input logic f7, input logic src,
                            input logic [4:0] a1, input logic [4:0] a2,
                            input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2, input logic [XLEN-1:0] im);
        in_valid = 1'b1; alu_op = op; funct3 = f3; funct7_5 = f7; alu_src = src;
        rs1_addr = a1; rs2_addr = a2; rs1_data = d1; rs2_data = d2; imm = im;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; funct3 = '0; funct7_5 = 1'b0; alu_src = 1'b0;
        rs1_addr = '0; rs2_addr = '0; rs1_data = '0; rs2_data = '0; imm = '0;
        exm_wr = 1'b0; mwb_wr = 1'b0; exm_rd = '0; mwb_rd = '0; exm_data = '0; mwb_data = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst out_valid", out_valid, 1'b0);
        check("rst alu_a", alu_a, 32'h0);
        check("rst alu_b", alu_b, 32'h0);
        check("rst alu_control", alu_control, 4'b0000);
        check("rst illegal", illegal, 1'b0);
        check("rst stall_cnt", stall_cnt, 4'h0);
        rst_n = 1'b1;
        #1 check("rst in_ready", in_ready, 1'b1);

        // Decode sweep, back-to-back with out_ready high.
        drive_op(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 32'd10, 32'd3, 32'h0); tick();
        check("sub ctrl", alu_control, 4'b0110);
        check("sub a", alu_a, 32'd10);
        check("sub b", alu_b, 32'd3);
        drive_op(2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 5'd2, 32'h0F, 32'h3C, 32'h0); tick();
        check("and ctrl", alu_control, 4'b0000);
        drive_op(2'b10, 3'b100, 1'b0, 1'b0, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0); tick();
        check("f3=100 ctrl", alu_control, 4'b1111);
        check("f3=100 illegal", illegal, 1'b1);
        check("illegal issued", out_valid, 1'b1);
        drive_op(2'b11, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 32'h4, 32'h5, 32'h0); tick();
        check("op11 ctrl", alu_control, 4'b1111);
        check("op11 illegal", illegal, 1'b1);
        drive_op(2'b00, 3'b010, 1'b1, 1'b1, 5'd3, 5'd4, 32'h40, 32'h50, 32'h100); tick();
        check("imm b", alu_b, 32'h100);
        drive_op(2'b10, 3'b110, 1'b1, 1'b0, 5'd3, 5'd4, 32'h6, 32'h7, 32'h0); tick();
        check("or ctrl", alu_control, 4'b0001);
        drive_op(2'b01, 3'b111, 1'b0, 1'b0, 5'd3, 5'd4, 32'h8, 32'h9, 32'h0); tick();

        // Forwarding: EX/MEM priority, x0 never forwarded, MEM/WB on rs2.
        exm_wr = 1'b1; exm_rd = 5'd5; exm_data = 32'hAA;
        mwb_wr = 1'b1; mwb_rd = 5'd5; mwb_data = 32'hBB;
        drive_op(2'b00, 3'b000, 1'b0, 1'b0, 5'd5, 5'd6, 32'h11, 32'h22, 32'h0); tick();
        check("fwd priority a", alu_a, EXP_A_FWD);
        check("fwd none b", alu_b, 32'h22);
        exm_rd = 5'd0; mwb_rd = 5'd0;
        drive_op(2'b00, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 32'h33, 32'h44, 32'h0); tick();
        check("fwd x0 a", alu_a, 32'h33);
        exm_rd = 5'd5; mwb_rd = 5'd9;
        drive_op(2'b00, 3'b000, 1'b0, 1'b0, 5'd7, 5'd9, 32'h01, 32'h02, 32'h0); tick();
        check("fwd mwb b", alu_b, EXP_B_FWD);
        exm_wr = 1'b0; mwb_wr = 1'b0;

        // Back-pressure: hold op X for 4 cycles, then drain back-to-back.
        drive_op(2'b10, 3'b110, 1'b0, 1'b0, 5'd1, 5'd2, 32'h5, 32'h6, 32'h0); tick();
        out_ready = 1'b0;
        drive_op(2'b10, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 32'h7, 32'h8, 32'h0);
        repeat (4) tick();
        check("bp stall_cnt", stall_cnt, 4'd4);
        check("bp in_ready", in_ready, 1'b0);
        check("bp held a", alu_a, 32'h5);
        out_ready = 1'b1; tick();
        check("bp next a", alu_a, 32'h7);
        drive_op(2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 5'd2, 32'h9, 32'hA, 32'h0); tick();
        check("bp b2b valid", out_valid, 1'b1);

        // Flush overrides a held op and a simultaneous offer.
        out_ready = 1'b0; flush = 1'b1;
        drive_op(2'b00, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 32'hB, 32'hC, 32'h0); tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush valid", out_valid, 1'b0);
        check("flush no capture", alu_a, 32'h9);
        check("flush stall_cnt", stall_cnt, 4'd5);

        // Saturation of the 4-bit counter.
        drive_op(2'b00, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2, 32'h21, 32'h22, 32'h0); tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("sat stall_cnt", stall_cnt, 4'hF);

        // Handoff with no new accept keeps data fields.
        out_ready = 1'b1; tick();
        check("drain valid", out_valid, 1'b0);
        check("drain retain a", alu_a, 32'h21);

        // Asynchronous reset mid-operation.
        out_ready = 1'b0;
        drive_op(2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 5'd2, 32'h31, 32'h32, 32'h0); tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid rst out_valid", out_valid, 1'b0);
        check("mid rst alu_a", alu_a, 32'h0);
        check("mid rst alu_b", alu_b, 32'h0);
        check("mid rst ctrl", alu_control, 4'b0000);
        check("mid rst stall_cnt", stall_cnt, 4'h0);
        sb.delete();
        exp_stall = '0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
